// File: rtl/osc_core.sv
// Phase-accumulator oscillator with square/saw/triangle mixer.
// Frequency and duty are double-buffered and committed only at phase wrap.
module osc_core #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 osc_en,
    input  logic                 sw_gate,
    input  logic                 en_square,
    input  logic                 en_saw,
    input  logic                 en_tri,
    input  logic [ACC_WIDTH-1:0] freq_word,
    input  logic [OUT_WIDTH-1:0] duty,
    output logic [OUT_WIDTH-1:0] wave_out,
    output logic                 phase_wrap,
    output logic                 osc_running,
    output logic                 gate_active
);

    localparam int SUM_W  = OUT_WIDTH + 2;
    localparam int PROD_W = 2 * OUT_WIDTH + 1;
    localparam logic [OUT_WIDTH-1:0] MID   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] THIRD = OUT_WIDTH'((1 << OUT_WIDTH) / 3);

    logic [ACC_WIDTH-1:0] phase_q, phase_d;
    logic [ACC_WIDTH-1:0] freq_q, freq_d;
    logic [OUT_WIDTH-1:0] duty_q, duty_d;
    logic [OUT_WIDTH-1:0] wave_q, wave_d;
    logic                 wrap_q, wrap_d;
    logic                 running_q, running_d;
    logic                 gate_q, gate_d;

    logic [ACC_WIDTH:0]   acc_sum;
    logic [OUT_WIDTH-1:0] p, saw_w, sq_w, tri_w, mix;
    logic [1:0]           n_en;
    logic [SUM_W-1:0]     sum;
    logic [PROD_W-1:0]    prod;

    // Stage 1: accumulator; shadow registers reload at carry or when stuck at zero
    always_comb begin
        acc_sum   = {1'b0, phase_q} + {1'b0, freq_q};
        running_d = osc_en;
        phase_d   = phase_q;
        wrap_d    = 1'b0;
        freq_d    = freq_q;
        duty_d    = duty_q;
        if (!osc_en) begin
            phase_d = '0;
            freq_d  = freq_word;
            duty_d  = duty;
        end else begin
            phase_d = acc_sum[ACC_WIDTH-1:0];
            wrap_d  = acc_sum[ACC_WIDTH];
            if (acc_sum[ACC_WIDTH] || (freq_q == '0)) begin
                freq_d = freq_word;
                duty_d = duty;
            end
        end
    end

    // Stage 2: waveform generation and mixing from the registered phase
    always_comb begin
        p     = phase_q[ACC_WIDTH-1 -: OUT_WIDTH];
        saw_w = p;
        sq_w  = (p < duty_q) ? '1 : '0;
        tri_w = p[OUT_WIDTH-1] ? ~{p[OUT_WIDTH-2:0], 1'b0} : {p[OUT_WIDTH-2:0], 1'b0};
        n_en  = {1'b0, en_square} + {1'b0, en_saw} + {1'b0, en_tri};
        sum   = (en_square ? {2'b00, sq_w}  : '0)
              + (en_saw    ? {2'b00, saw_w} : '0)
              + (en_tri    ? {2'b00, tri_w} : '0);
        prod  = {{(OUT_WIDTH-1){1'b0}}, sum} * {{(OUT_WIDTH+1){1'b0}}, THIRD};
        case (n_en)
            2'd0:    mix = MID;
            2'd1:    mix = sum[OUT_WIDTH-1:0];
            2'd2:    mix = sum[OUT_WIDTH:1];
            default: mix = prod[2*OUT_WIDTH-1:OUT_WIDTH];
        endcase
        gate_d = sw_gate & running_q;
        wave_d = gate_d ? mix : MID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            freq_q    <= '0;
            duty_q    <= MID;
            wave_q    <= MID;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            freq_q    <= freq_d;
            duty_q    <= duty_d;
            wave_q    <= wave_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            gate_q    <= gate_d;
        end
    end

    assign wave_out    = wave_q;
    assign phase_wrap  = wrap_q;
    assign osc_running = running_q;
    assign gate_active = gate_q;

endmodule

// File: tb/tb_osc_core.sv
// Directed bench for osc_core: ramp, square, frequency commit at wrap, mixing,
// gating, zero-frequency freeze, enable fall and asynchronous reset.
module tb_osc_core;

    logic        clk;
    logic        rst_n;
    logic        osc_en;
    logic        sw_gate;
    logic        en_square;
    logic        en_saw;
    logic        en_tri;
    logic [23:0] freq_word;
    logic [7:0]  duty;
    logic [7:0]  wave_out;
    logic        phase_wrap;
    logic        osc_running;
    logic        gate_active;

    int total;
    int bad;

    osc_core #(.ACC_WIDTH(24), .OUT_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .osc_en      (osc_en),
        .sw_gate     (sw_gate),
        .en_square   (en_square),
        .en_saw      (en_saw),
        .en_tri      (en_tri),
        .freq_word   (freq_word),
        .duty        (duty),
        .wave_out    (wave_out),
        .phase_wrap  (phase_wrap),
        .osc_running (osc_running),
        .gate_active (gate_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two idle clocks load the shadow registers, then enable; returns just after edge E1.
    task automatic restart(input logic [23:0] f, input logic [7:0] d,
                           input logic sq, input logic sw, input logic tr);
        osc_en    = 1'b0;
        sw_gate   = 1'b1;
        freq_word = f;
        duty      = d;
        en_square = sq;
        en_saw    = sw;
        en_tri    = tr;
        tick();
        tick();
        check_val("idle_wave", {24'h0, wave_out}, 32'h80);
        check_val("idle_running", {31'h0, osc_running}, 32'h0);
        osc_en = 1'b1;
        tick();
        check_val("e1_running", {31'h0, osc_running}, 32'h1);
        check_val("e1_wave", {24'h0, wave_out}, 32'h80);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        osc_en    = 1'b0;
        sw_gate   = 1'b0;
        en_square = 1'b0;
        en_saw    = 1'b0;
        en_tri    = 1'b0;
        freq_word = 24'h0;
        duty      = 8'h80;
        #23;
        check_val("rst_wave", {24'h0, wave_out}, 32'h80);
        check_val("rst_wrap", {31'h0, phase_wrap}, 32'h0);
        check_val("rst_running", {31'h0, osc_running}, 32'h0);
        check_val("rst_gate", {31'h0, gate_active}, 32'h0);
        rst_n = 1'b1;

        // Saw ramp at step 1, then step 2 written mid-period and committed at wrap
        restart(24'h010000, 8'h80, 1'b0, 1'b1, 1'b0);
        for (int k = 2; k <= 642; k++) begin
            tick();
            if (k <= 512) begin
                check_val("ramp_wave", {24'h0, wave_out}, (k - 1) & 32'hFF);
                check_val("ramp_wrap", {31'h0, phase_wrap}, (k % 256 == 0) ? 32'h1 : 32'h0);
            end else begin
                check_val("ramp2_wave", {24'h0, wave_out}, (2 * (k - 513)) & 32'hFF);
                check_val("ramp2_wrap", {31'h0, phase_wrap}, ((k - 512) % 128 == 0) ? 32'h1 : 32'h0);
            end
            if (k == 2) check_val("ramp_gate", {31'h0, gate_active}, 32'h1);
            if (k == 304) freq_word = 24'h020000;
        end

        // Square, duty 0x40: high while p < 0x40
        restart(24'h010000, 8'h40, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 257; k++) begin
            tick();
            check_val("sq40_wave", {24'h0, wave_out}, (((k - 1) & 255) < 64) ? 32'hFF : 32'h00);
        end

        // Square, duty 0x00: constant low
        restart(24'h010000, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            tick();
            check_val("sq00_wave", {24'h0, wave_out}, 32'h00);
        end

        // Zero frequency: phase frozen at 0, three-way mix = 0x54
        restart(24'h000000, 8'h80, 1'b1, 1'b1, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_val("mix3_wave", {24'h0, wave_out}, 32'h54);
            check_val("freeze_wrap", {31'h0, phase_wrap}, 32'h0);
        end
        en_square = 1'b0;
        en_tri    = 1'b0;
        tick();
        check_val("saw_only_p0", {24'h0, wave_out}, 32'h00);
        freq_word = 24'h000100;
        for (int m = 1; m <= 258; m++) begin
            tick();
            if (m == 257) check_val("slow_p0", {24'h0, wave_out}, 32'h00);
            if (m == 258) check_val("slow_p1", {24'h0, wave_out}, 32'h01);
        end

        // Saw + tri, then gating while running, then enable fall
        restart(24'h010000, 8'h80, 1'b0, 1'b1, 1'b1);
        for (int k = 2; k <= 65; k++) begin
            tick();
            if (k == 2)  check_val("sawtri_p01", {24'h0, wave_out}, 32'h01);
            if (k == 65) check_val("sawtri_p40", {24'h0, wave_out}, 32'h60);
        end
        sw_gate = 1'b0;
        for (int k = 66; k <= 256; k++) begin
            tick();
            if (k == 66) begin
                check_val("ungate_gate", {31'h0, gate_active}, 32'h0);
                check_val("ungate_wave", {24'h0, wave_out}, 32'h80);
            end
            if (k == 255) check_val("ungate_nowrap", {31'h0, phase_wrap}, 32'h0);
            if (k == 256) begin
                check_val("ungate_wrap", {31'h0, phase_wrap}, 32'h1);
                check_val("ungate_wave2", {24'h0, wave_out}, 32'h80);
            end
        end
        sw_gate = 1'b1;
        tick();
        check_val("regate_gate", {31'h0, gate_active}, 32'h1);
        check_val("regate_wave", {24'h0, wave_out}, 32'h00);
        tick();
        check_val("regate_wave1", {24'h0, wave_out}, 32'h01);
        osc_en = 1'b0;
        tick();
        check_val("off_running", {31'h0, osc_running}, 32'h0);
        check_val("off_wrap", {31'h0, phase_wrap}, 32'h0);
        tick();
        check_val("off_wave", {24'h0, wave_out}, 32'h80);
        check_val("off_gate", {31'h0, gate_active}, 32'h0);

        // Asynchronous reset mid-ramp, release with the oscillator enabled
        restart(24'h010000, 8'h80, 1'b0, 1'b1, 1'b0);
        for (int k = 2; k <= 100; k++) tick();
        check_val("pre_rst_wave", {24'h0, wave_out}, 32'd99);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_wave", {24'h0, wave_out}, 32'h80);
        check_val("arst_running", {31'h0, osc_running}, 32'h0);
        check_val("arst_gate", {31'h0, gate_active}, 32'h0);
        check_val("arst_wrap", {31'h0, phase_wrap}, 32'h0);
        freq_word = 24'h020000;
        #2;
        rst_n = 1'b1;
        tick();
        check_val("rel_running", {31'h0, osc_running}, 32'h1);
        check_val("rel_wave_e1", {24'h0, wave_out}, 32'h80);
        tick();
        check_val("rel_wave_e2", {24'h0, wave_out}, 32'h00);
        tick();
        check_val("rel_wave_e3", {24'h0, wave_out}, 32'h02);
        tick();
        check_val("rel_wave_e4", {24'h0, wave_out}, 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
